// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Owns the single write port of the register file. After reset it sweeps
//   zero into every register (x0..x{REG_COUNT-1}), one per cycle. It then
//   round-robin arbitrates between two writeback sources: A (ALU result) and
//   B (load result). All write-port outputs are registered at posedge, so
//   they are stable when the register file samples them at the next negedge.
//
// Ports:
//   i_clk        clock; all state changes on posedge
//   i_reset      synchronous, active-high reset
//   i_a_valid    source A has a write pending
//   o_a_ready    source A granted this cycle (combinational)
//   i_a_rd       source A destination register
//   i_a_data     source A write data
//   i_b_valid    source B has a write pending
//   o_b_ready    source B granted this cycle (combinational)
//   i_b_rd       source B destination register
//   i_b_data     source B write data
//   o_init_done  high once the clear sweep has completed (registered)
//   o_wb_we      register-file write enable (registered)
//   o_wb_rd      register-file write index (registered)
//   o_wb_data    register-file write data (registered)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int XLEN      = 64,
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_a_valid,
  output logic              o_a_ready,
  input  logic [ADDR_W-1:0] i_a_rd,
  input  logic [XLEN-1:0]   i_a_data,
  input  logic              i_b_valid,
  output logic              o_b_ready,
  input  logic [ADDR_W-1:0] i_b_rd,
  input  logic [XLEN-1:0]   i_b_data,
  output logic              o_init_done,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_rd,
  output logic [XLEN-1:0]   o_wb_data
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  // Index of the final register written by the clear sweep.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

  // r_lastGrant encoding: 0 = source A won most recently, 1 = source B.
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_initPtr;
  logic              r_lastGrant;
  logic              r_initDone;
  logic              r_wbWe;
  logic [ADDR_W-1:0] r_wbRd;
  logic [XLEN-1:0]   r_wbData;

  logic              w_grantA;
  logic              w_grantB;
  logic              w_nextWe;
  logic [ADDR_W-1:0] w_nextRd;
  logic [XLEN-1:0]   w_nextData;
  logic              w_nextDone;
  logic              w_sweepLast;

  assign w_sweepLast = (r_initPtr == LAST_IDX);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: the sweep hands over to arbitration on its last write,
  // and arbitration is only left through reset.
  always_comb begin
    w_nextState = r_state;
    if (r_state == ST_INIT && w_sweepLast) begin
      w_nextState = ST_ARB;
    end
  end

  // Output logic: grants plus the values the write port registers next edge.
  // Grants are gated by reset so nothing can be accepted while it is high.
  // On a tie the source that did not win last time is granted.
  always_comb begin
    w_grantA   = 1'b0;
    w_grantB   = 1'b0;
    w_nextWe   = 1'b0;
    w_nextRd   = r_wbRd;
    w_nextData = r_wbData;
    w_nextDone = r_initDone;
    if (r_state == ST_INIT) begin
      w_nextWe   = 1'b1;
      w_nextRd   = r_initPtr;
      w_nextData = '0;
      if (w_sweepLast) begin
        w_nextDone = 1'b1;
      end
    end else if (!i_reset) begin
      w_grantA = i_a_valid && (!i_b_valid || r_lastGrant == GRANT_B);
      w_grantB = i_b_valid && (!i_a_valid || r_lastGrant == GRANT_A);
      // A write to x0 is accepted but suppressed so x0 stays zero.
      if (w_grantA) begin
        w_nextWe   = (i_a_rd != '0);
        w_nextRd   = i_a_rd;
        w_nextData = i_a_data;
      end else if (w_grantB) begin
        w_nextWe   = (i_b_rd != '0);
        w_nextRd   = i_b_rd;
        w_nextData = i_b_data;
      end
    end
  end

  // Datapath registers: sweep pointer, fairness history and the write port.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_initPtr   <= '0;
      r_lastGrant <= GRANT_B;
      r_initDone  <= 1'b0;
      r_wbWe      <= 1'b0;
      r_wbRd      <= '0;
      r_wbData    <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        r_initPtr <= r_initPtr + 1'b1;
      end
      if (w_grantA) begin
        r_lastGrant <= GRANT_A;
      end else if (w_grantB) begin
        r_lastGrant <= GRANT_B;
      end
      r_initDone <= w_nextDone;
      r_wbWe     <= w_nextWe;
      r_wbRd     <= w_nextRd;
      r_wbData   <= w_nextData;
    end
  end

  assign o_a_ready   = w_grantA;
  assign o_b_ready   = w_grantB;
  assign o_init_done = r_initDone;
  assign o_wb_we     = r_wbWe;
  assign o_wb_rd     = r_wbRd;
  assign o_wb_data   = r_wbData;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Purpose:
//   Self-checking bench for regfile_wb_arbiter. Directed scenarios (clear
//   sweep, single source, contention, x0 discard, streaming, mid-operation
//   resets) are followed by randomized traffic with random resets. A
//   reference model tracks cycles since reset, which source is preferred on
//   a tie, and the expected write-port contents.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int XLEN      = 64;
  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              aValid, bValid;
  logic              aReady, bReady;
  logic [ADDR_W-1:0] aRd, bRd;
  logic [XLEN-1:0]   aData, bData;
  logic              initDone, wbWe;
  logic [ADDR_W-1:0] wbRd;
  logic [XLEN-1:0]   wbData;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state.
  int                mCyc;
  bit                mPreferA;
  logic              expWe;
  logic [ADDR_W-1:0] expRd;
  logic [XLEN-1:0]   expData;
  logic              expDone;

  logic gotA, gotB;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .XLEN(XLEN),
    .REG_COUNT(REG_COUNT),
    .ADDR_W(ADDR_W)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_a_valid(aValid),
    .o_a_ready(aReady),
    .i_a_rd(aRd),
    .i_a_data(aData),
    .i_b_valid(bValid),
    .o_b_ready(bReady),
    .i_b_rd(bRd),
    .i_b_data(bData),
    .o_init_done(initDone),
    .o_wb_we(wbWe),
    .o_wb_rd(wbRd),
    .o_wb_data(wbData)
  );

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs after the negedge, checks the grants, steps
  // the model through the posedge and checks the registered write port.
  task automatic applyStimulus(input logic rst,
                               input logic av, input logic [ADDR_W-1:0] ard,
                               input logic [XLEN-1:0] ad,
                               input logic bv, input logic [ADDR_W-1:0] brd,
                               input logic [XLEN-1:0] bd,
                               output logic grantedA, output logic grantedB);
    logic eA, eB;
    @(negedge clk);
    reset  = rst;
    aValid = av; aRd = ard; aData = ad;
    bValid = bv; bRd = brd; bData = bd;
    #1;
    if (rst || mCyc < REG_COUNT) begin
      eA = 1'b0; eB = 1'b0;
    end else if (av && bv) begin
      eA = mPreferA; eB = !mPreferA;
    end else begin
      eA = av; eB = bv;
    end
    checkOutput("a_ready", {63'd0, aReady}, {63'd0, eA});
    checkOutput("b_ready", {63'd0, bReady}, {63'd0, eB});
    checkOutput("ready_mutex", {63'd0, aReady & bReady}, 64'd0);

    if (rst) begin
      mCyc = 0; mPreferA = 1'b1;
      expWe = 1'b0; expRd = '0; expData = '0; expDone = 1'b0;
    end else if (mCyc < REG_COUNT) begin
      expWe = 1'b1; expRd = ADDR_W'(mCyc); expData = '0;
      mCyc++;
      expDone = (mCyc == REG_COUNT);
    end else if (eA) begin
      expWe = (ard != 0); expRd = ard; expData = ad; mPreferA = 1'b0;
    end else if (eB) begin
      expWe = (brd != 0); expRd = brd; expData = bd; mPreferA = 1'b1;
    end else begin
      expWe = 1'b0;
    end

    @(posedge clk);
    #1;
    checkOutput("wb_we", {63'd0, wbWe}, {63'd0, expWe});
    checkOutput("wb_rd", {59'd0, wbRd}, {59'd0, expRd});
    checkOutput("wb_data", wbData, expData);
    checkOutput("init_done", {63'd0, initDone}, {63'd0, expDone});
    grantedA = eA;
    grantedB = eB;
  endtask

  initial begin
    logic              pA, pB;
    logic [ADDR_W-1:0] rA, rB;
    logic [XLEN-1:0]   dA, dB;

    reset = 1'b1;
    aValid = 1'b0; aRd = '0; aData = '0;
    bValid = 1'b0; bRd = '0; bData = '0;
    mCyc = 0; mPreferA = 1'b1;
    expWe = 1'b0; expRd = '0; expData = '0; expDone = 1'b0;

    $display("[TB] reset and clear sweep");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 5'd9, 64'h9, 1'b1, 5'd10, 64'hA, gotA, gotB);
    for (int i = 0; i < REG_COUNT; i++)
      applyStimulus(1'b0, 1'b1, 5'd9, 64'h9, 1'b1, 5'd10, 64'hA, gotA, gotB);
    // First tie after the sweep must go to A.
    applyStimulus(1'b0, 1'b1, 5'd9, 64'h9, 1'b1, 5'd10, 64'hA, gotA, gotB);
    checkOutput("first_tie_A", {63'd0, gotA}, 64'd1);
    // B, having lost, is served next.
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd10, 64'hA, gotA, gotB);

    $display("[TB] single source");
    applyStimulus(1'b0, 1'b1, 5'd5, 64'hDEADBEEF, 1'b0, 5'd0, 64'h0, gotA, gotB);
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, gotA, gotB);

    $display("[TB] contention");
    dA = 64'h11; dB = 64'h22;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 5'd1, dA, 1'b1, 5'd2, dB, gotA, gotB);
      if (gotA) dA = dA + 64'h100;
      if (gotB) dB = dB + 64'h100;
    end

    $display("[TB] x0 discard");
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 64'hFFFF, gotA, gotB);
    applyStimulus(1'b0, 1'b1, 5'd12, 64'h1212, 1'b1, 5'd13, 64'h1313, gotA, gotB);
    checkOutput("tie_after_x0_A", {63'd0, gotA}, 64'd1);

    $display("[TB] streaming");
    for (int i = 3; i <= 7; i++)
      applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, ADDR_W'(i), 64'h700 + 64'(i), gotA, gotB);
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, gotA, gotB);

    $display("[TB] reset mid-sweep");
    applyStimulus(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, gotA, gotB);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b1, 5'd4, 64'h4, 1'b0, 5'd0, 64'h0, gotA, gotB);
    applyStimulus(1'b1, 1'b1, 5'd4, 64'h4, 1'b0, 5'd0, 64'h0, gotA, gotB);
    for (int i = 0; i < REG_COUNT + 1; i++)
      applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd6, 64'h66, gotA, gotB);

    $display("[TB] reset during acceptance in arbitration");
    applyStimulus(1'b1, 1'b1, 5'd8, 64'hBAD0BAD0, 1'b0, 5'd0, 64'h0, gotA, gotB);
    for (int i = 0; i < REG_COUNT + 1; i++)
      applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, gotA, gotB);

    $display("[TB] randomized traffic");
    pA = 1'b0; pB = 1'b0; rA = '0; rB = '0; dA = '0; dB = '0;
    for (int i = 0; i < 600; i++) begin
      logic rst;
      if (!pA && $urandom_range(0, 2) != 0) begin
        pA = 1'b1; rA = ADDR_W'($urandom_range(0, 31)); dA = {$urandom, $urandom};
      end
      if (!pB && $urandom_range(0, 2) != 0) begin
        pB = 1'b1; rB = ADDR_W'($urandom_range(0, 31)); dB = {$urandom, $urandom};
      end
      rst = ($urandom_range(0, 79) == 0);
      applyStimulus(rst, pA, rA, dA, pB, rB, dB, gotA, gotB);
      if (gotA) pA = 1'b0;
      if (gotB) pB = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
